serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes operands DIGIT bits per clock, keeping a registered carry between steps. It is the sequential successor to the single-bit full adder and chains that adder's sum/carry equations across a WIDTH-bit word under a start/done handshake. It is the arithmetic block for datapaths that trade latency for area.

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per cycle, start/done handshake
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(STEPS + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d, nres;
  logic c_q, c_d, busy_q, busy_d, done_q, done_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [DIGIT:0] slice;
  logic last, cmsb;
  assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  assign cmsb = slice[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign last = cnt_q == CW'(STEPS - 1);
  // result shifts in from the top so the LSB slice ends up at bit 0
  if (DIGIT == WIDTH) begin : g_full
    assign nres = slice[DIGIT-1:0];
  end else begin : g_part
    assign nres = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    res_d = res_q;
    busy_d = busy_q;
    done_d = 1'b0;
    sum_d = sum_q;
    carry_d = carry_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        a_d = a;
        b_d = b ^ {WIDTH{sub}};
        c_d = cin ^ sub;
        cnt_d = '0;
        busy_d = 1'b1;
      end
    end else begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      c_d = slice[DIGIT];
      res_d = nres;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        sum_d = nres;
        carry_d = slice[DIGIT];
        ovf_d = cmsb ^ slice[DIGIT];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      res_q <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign carry = carry_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for 8x1, 8x4 and 1x1 configurations
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start8 = 0, sub8 = 0, cin8 = 0, busy8, done8, c8, v8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic start4 = 0, sub4 = 0, cin4 = 0, busy4, done4, c4, v4;
  logic [7:0] a4 = 0, b4 = 0, sum4;
  logic start1 = 0, sub1 = 0, cin1 = 0, busy1, done1, c1, v1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .carry(c8), .overflow(v8));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .carry(c4), .overflow(v4));
  serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
    .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .carry(c1), .overflow(v1));
  typedef struct {
    logic sub;
    logic [7:0] a, b;
    logic cin;
    logic [7:0] s;
    logic c, v;
  } vec_t;
  vec_t tbl[8];
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic launch8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci);
    @(negedge clk);
    sub8 = s; a8 = x; b8 = y; cin8 = ci; start8 = 1;
    @(negedge clk);
    start8 = 0;
  endtask
  // counts edges until done; also flags any cycle where sum moved or busy dropped early
  task automatic wait_done8(input int k0, output int k, output logic held);
    logic [7:0] prev;
    prev = sum8;
    held = 1;
    k = k0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
      if (!done8 && (sum8 !== prev || !busy8)) held = 0;
    end
  endtask
  task automatic run8(input vec_t t, input string name);
    int k;
    logic held;
    launch8(t.sub, t.a, t.b, t.cin);
    wait_done8(0, k, held);
    chk({name, " latency"}, k, 8);
    chk({name, " hold"}, held, 1);
    chk({name, " sum"}, sum8, t.s);
    chk({name, " carry"}, c8, t.c);
    chk({name, " ovf"}, v8, t.v);
  endtask
  task automatic run4(input logic s, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] es, input logic ec, input logic ev, input string name);
    int k;
    @(negedge clk);
    sub4 = s; a4 = x; b4 = y; cin4 = 0; start4 = 1;
    @(negedge clk);
    start4 = 0;
    k = 0;
    while (!done4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, k, 2);
    chk({name, " sum"}, sum4, es);
    chk({name, " carry"}, c4, ec);
    chk({name, " ovf"}, v4, ev);
  endtask
  initial begin
    int k;
    logic held, flag;
    tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h3C, 8'h0C, 1'b0, 8'h30, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset state", {busy8, done8, sum8, c8, v8}, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) run8(tbl[i], $sformatf("vec%0d", i));
    // asynchronous reset pulse with start held high
    @(posedge clk);
    start8 = 1;
    #2 rst_n = 0;
    #1 chk("async reset", {busy8, done8, sum8, c8, v8}, 0);
    @(negedge clk);
    start8 = 0;
    rst_n = 1;
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if ({busy8, done8, sum8, c8, v8} !== 0) flag = 1;
    end
    chk("stay zero after reset", flag, 0);
    run8(tbl[0], "post reset");
    // start after E3 of a running op is ignored
    launch8(1'b0, 8'h0F, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    sub8 = 1; a8 = 8'h55; b8 = 8'h55; start8 = 1;
    @(negedge clk);
    start8 = 0;
    wait_done8(3, k, held);
    chk("repulse latency", k, 8);
    chk("repulse hold", held, 1);
    chk("repulse sum", sum8, 8'h10);
    chk("repulse carry", c8, 0);
    // start in the done cycle is accepted
    sub8 = 0; a8 = 8'h22; b8 = 8'h11; cin8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    chk("done-cycle busy/done", {busy8, done8}, 2'b10);
    wait_done8(0, k, held);
    chk("done-cycle latency", k, 8);
    chk("done-cycle hold", held, 1);
    chk("done-cycle sum", sum8, 8'h33);
    // reset at E4 aborts without a done pulse
    launch8(1'b0, 8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1 chk("abort outputs", {busy8, done8, sum8, c8, v8}, 0);
    @(negedge clk);
    rst_n = 1;
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 || busy8) flag = 1;
    end
    chk("abort no done", flag, 0);
    run8('{1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0}, "after abort");
    run4(1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, "d4 add");
    run4(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "d4 sub");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 0; start1 = 1;
      @(negedge clk);
      start1 = 0;
      k = 0;
      while (!done1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("fa%0d latency", i), k, 1);
      chk($sformatf("fa%0d sum", i), sum1, v[2] ^ v[1] ^ v[0]);
      chk($sformatf("fa%0d carry", i), c1, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
